// File: rtl/modulo_seq_pkg.sv
// Shared types and default sizes for the modulo sequence controller.
// Optional feature macro used by the controller: MODULO_SEQ_PAUSE_EN.
package modulo_seq_pkg;

  localparam int unsigned CNT_W_DEF = 3;
  localparam int unsigned REP_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/modulo_tick.sv
// Modulo counter datapath: count register, terminal-count compare and
// the toggle flop that inverts on every wrap. Sequencing comes from the FSM.
module modulo_tick #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] modulus,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             tog
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tog_q, tog_d;

  // Wrap is a direct compare, so an all-ones modulus wraps before any overflow.
  assign wrap  = (count_q == modulus);
  assign count = count_q;
  assign tog   = tog_q;

  // Next count/toggle: clear wins over enable and never touches the toggle.
  always_comb begin
    count_d = count_q;
    tog_d   = tog_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (wrap) begin
        count_d = '0;
        tog_d   = ~tog_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Counter and toggle registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tog_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tog_q   <= tog_d;
    end
  end

endmodule

// File: rtl/modulo_seq_ctrl.sv
// Modulo sequence controller: accepts a (modulus, repeat) command, runs a
// 0..M counter with a wrap toggle for the requested number of wraps (or
// forever when reps is 0), and pulses done on normal completion.
// Optional feature: define MODULO_SEQ_PAUSE_EN to add the pause input.
module modulo_seq_ctrl
  import modulo_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_modulus,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             stop,
`ifdef MODULO_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  output logic [CNT_W-1:0] state,
  output logic             out,
  output logic             busy,
  output logic             done
);

  seq_state_e       fsm_q, fsm_d;
  logic [CNT_W-1:0] mod_q, mod_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [REP_W-1:0] wraps_q, wraps_d;
  logic             pause_i;
  logic             tick_en;
  logic             tick_clr;
  logic             wrap;
  logic [CNT_W-1:0] count;
  logic             tog;

`ifdef MODULO_SEQ_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  modulo_tick #(
    .CNT_W (CNT_W)
  ) u_tick (
    .clk     (clk),
    .rst_n   (reset),
    .en      (tick_en),
    .clr     (tick_clr),
    .modulus (mod_q),
    .count   (count),
    .wrap    (wrap),
    .tog     (tog)
  );

  assign state = count;
  assign out   = tog;

  // Next-state, command latching, wrap accounting and status outputs.
  // Stop is checked before pause and wrap so it overrides both.
  always_comb begin
    fsm_d     = fsm_q;
    mod_d     = mod_q;
    reps_d    = reps_q;
    wraps_d   = wraps_q;
    tick_en   = 1'b0;
    tick_clr  = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          mod_d    = cmd_modulus;
          reps_d   = cmd_reps;
          wraps_d  = '0;
          tick_clr = 1'b1;
          fsm_d    = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (stop) begin
          tick_clr = 1'b1;
          fsm_d    = IDLE;
        end else if (!pause_i) begin
          tick_en = 1'b1;
          if (wrap) begin
            if (reps_q == '0) begin
              if (wraps_q != '1) begin
                wraps_d = wraps_q + 1'b1;
              end
            end else begin
              wraps_d = wraps_q + 1'b1;
              if (wraps_d == reps_q) begin
                fsm_d = DONE;
              end
            end
          end
        end
      end
      DONE: begin
        done  = 1'b1;
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // FSM and command registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q   <= IDLE;
      mod_q   <= '0;
      reps_q  <= '0;
      wraps_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      mod_q   <= mod_d;
      reps_q  <= reps_d;
      wraps_q <= wraps_d;
    end
  end

endmodule

// File: tb/tb_modulo_seq_ctrl.sv
// Self-checking bench for modulo_seq_ctrl with a cycle-level reference model.
// Pause scenario is built only when MODULO_SEQ_PAUSE_EN is defined.
module tb_modulo_seq_ctrl;

  localparam int unsigned CW = 3;
  localparam int unsigned RW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_modulus;
  logic [RW-1:0] cmd_reps;
  logic          stop;
  logic          pause;
  logic [CW-1:0] state;
  logic          out;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_out;

  always #5 clk = ~clk;

  modulo_seq_ctrl #(
    .CNT_W (CW),
    .REP_W (RW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_modulus (cmd_modulus),
    .cmd_reps    (cmd_reps),
    .stop        (stop),
`ifdef MODULO_SEQ_PAUSE_EN
    .pause       (pause),
`endif
    .state       (state),
    .out         (out),
    .busy        (busy),
    .done        (done)
  );

  // One command from IDLE (entered at a negedge). Expected values come from
  // arithmetic on the number of advancing RUN cycles: count = adv mod (M+1),
  // out flips once per completed M+1 block; completion after reps*(M+1).
  task automatic run_sequence(input string name, input int m, input int reps,
                              input int stop_at, input int pause_adv,
                              input int pause_len);
    int adv, k, total, paused;
    bit o0, exp_o;
    logic [CW+3:0] obs, expv;
    bit stopped;
    total   = reps * (m + 1);
    o0      = model_out;
    adv     = 0;
    paused  = 0;
    k       = 0;
    stopped = 1'b0;
    exp_o   = o0;
    cmd_valid   = 1'b1;
    cmd_modulus = CW'(m);
    cmd_reps    = RW'(reps);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (1) begin
      if (reps != 0 && adv == total) break;
      if (k > 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s timeout: got %0d RUN cycles, required completion by 2000", name, k);
        break;
      end
      exp_o = o0 ^ (((adv / (m + 1)) % 2) != 0);
      expv  = {1'b1, 1'b0, 1'b0, exp_o, CW'(adv % (m + 1))};
      obs   = {busy, done, cmd_ready, out, state};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL %s run cycle %0d {busy,done,ready,out,state}: got %b required %b",
                 name, k, obs, expv);
      end
      if (k == stop_at) begin
        stop = 1'b1;
        @(negedge clk);
        stop    = 1'b0;
        stopped = 1'b1;
        break;
      end
      if (pause_len > 0 && adv == pause_adv && paused < pause_len) begin
        pause = 1'b1;
        paused++;
      end else begin
        pause = 1'b0;
        adv++;
      end
      cmd_valid   = ($urandom_range(0, 3) == 0);
      cmd_modulus = CW'($urandom);
      cmd_reps    = RW'($urandom);
      @(negedge clk);
      k++;
    end
    pause     = 1'b0;
    cmd_valid = 1'b0;
    if (stopped) begin
      model_out = exp_o;
      expv = {1'b0, 1'b0, 1'b1, exp_o, CW'(0)};
      obs  = {busy, done, cmd_ready, out, state};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL %s after stop {busy,done,ready,out,state}: got %b required %b",
                 name, obs, expv);
      end
    end else if (k <= 2000) begin
      n_checks++;
      if (k !== reps * (m + 1) + pause_len) begin
        n_fail++;
        $display("FAIL %s run length: got %0d required %0d", name, k, reps * (m + 1) + pause_len);
      end
      exp_o = o0 ^ ((reps % 2) != 0);
      expv  = {1'b0, 1'b1, 1'b0, exp_o, CW'(0)};
      obs   = {busy, done, cmd_ready, out, state};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL %s done cycle {busy,done,ready,out,state}: got %b required %b",
                 name, obs, expv);
      end
      // stop and a command offered in DONE must both be ignored
      stop        = 1'b1;
      cmd_valid   = 1'b1;
      cmd_modulus = CW'($urandom);
      cmd_reps    = RW'($urandom);
      @(negedge clk);
      stop      = 1'b0;
      cmd_valid = 1'b0;
      model_out = exp_o;
      expv = {1'b0, 1'b0, 1'b1, exp_o, CW'(0)};
      obs  = {busy, done, cmd_ready, out, state};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL %s idle after done {busy,done,ready,out,state}: got %b required %b",
                 name, obs, expv);
      end
    end
  endtask

  task automatic test_reset();
    logic [CW+3:0] obs;
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_modulus = '0;
    cmd_reps    = '0;
    stop        = 1'b0;
    pause       = 1'b0;
    #12;
    obs = {busy, done, cmd_ready, out, state};
    n_checks++;
    if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, CW'(0)}) begin
      n_fail++;
      $display("FAIL reset_held: got %b required %b", obs, {1'b0, 1'b0, 1'b1, 1'b0, CW'(0)});
    end
    @(negedge clk);
    reset = 1'b1;
    // stop in IDLE must do nothing
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    obs = {busy, done, cmd_ready, out, state};
    n_checks++;
    if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, CW'(0)}) begin
      n_fail++;
      $display("FAIL reset_released: got %b required %b", obs, {1'b0, 1'b0, 1'b1, 1'b0, CW'(0)});
    end
    model_out = 1'b0;
  endtask

  task automatic test_basic();
    run_sequence("m2_reps2", 2, 2, -1, 0, 0);
  endtask

  task automatic test_modulus_zero();
    run_sequence("m0_reps3", 0, 3, -1, 0, 0);
  endtask

  task automatic test_max_freerun();
    run_sequence("m7_freerun_stop", 7, 0, 19, 0, 0);
  endtask

  task automatic test_stop_on_wrap();
    run_sequence("stop_on_wrap", 2, 3, 2, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    int target;
    logic [CW+3:0] obs;
    target      = model_out ? 0 : 2;
    cmd_valid   = 1'b1;
    cmd_modulus = CW'(1);
    cmd_reps    = '0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < target; i++) @(negedge clk);
    n_checks++;
    if (out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_run pre: got out=%b required 1", out);
    end
    #2;
    reset = 1'b0;
    #1;
    obs = {busy, done, cmd_ready, out, state};
    n_checks++;
    if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, CW'(0)}) begin
      n_fail++;
      $display("FAIL reset_mid_run async: got %b required %b", obs, {1'b0, 1'b0, 1'b1, 1'b0, CW'(0)});
    end
    @(negedge clk);
    reset = 1'b1;
    model_out = 1'b0;
    run_sequence("after_reset", 3, 2, -1, 0, 0);
  endtask

  task automatic test_random();
    int m, reps, stop_at;
    for (int i = 0; i < 10; i++) begin
      m    = $urandom_range(0, 7);
      reps = $urandom_range(0, 4);
      if (reps == 0) stop_at = $urandom_range(0, 30);
      else if ($urandom_range(0, 2) == 0) stop_at = $urandom_range(0, reps * (m + 1) - 1);
      else stop_at = -1;
      run_sequence($sformatf("random%0d", i), m, reps, stop_at, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    run_sequence("b2b_a", 1, 1, -1, 0, 0);
    run_sequence("b2b_b", 4, 2, -1, 0, 0);
  endtask

`ifdef MODULO_SEQ_PAUSE_EN
  task automatic test_pause();
    run_sequence("pause_m3", 3, 2, -1, 2, 4);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_modulus_zero();
    test_max_freerun();
    test_stop_on_wrap();
    test_reset_mid_run();
    test_back_to_back();
`ifdef MODULO_SEQ_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/modulo_seq_ctrl.md
MODULO_SEQ_CTRL -- requirements
Module: modulo_seq_ctrl

Interface
REQ-001 Parameter: CNT_W, default 3, width of the modulo count and of the modulus.
REQ-002 Parameter: REP_W, default 8, width of the repeat (wrap) count.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately.
REQ-005 Port: cmd_valid  input  1  command offered.
REQ-006 Port: cmd_ready  output  1  command can be accepted.
REQ-007 Port: cmd_modulus  input  CNT_W  terminal count M; the counter runs 0..M.
REQ-008 Port: cmd_reps  input  REP_W  wraps before completion; 0 means free-run.
REQ-009 Port: stop  input  1  abort the running sequence.
REQ-010 Port: state  output  CNT_W  current count value.
REQ-011 Port: out  output  1  toggle output; inverts on every wrap.
REQ-012 Port: busy  output  1  high while the FSM is in RUN.
REQ-013 Port: done  output  1  one-cycle pulse on normal completion.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE; accept = cmd_valid & cmd_ready.
REQ-016 On accept: latch M and reps, count<=0, wraps<=0, next state RUN; out keeps its value.
REQ-017 In RUN, when count==M: count<=0, out<=~out, wraps<=wraps+1; otherwise count<=count+1.
REQ-018 M=0: count stays 0; out toggles every RUN cycle.
REQ-019 M=2^CNT_W-1: the wrap occurs at the all-ones count; there is no arithmetic overflow past M.
REQ-020 reps!=0: the cycle whose wrap makes wraps+1==reps performs that wrap (toggle included) and moves to DONE.
REQ-021 reps=0: RUN continues indefinitely; the wrap counter saturates and is ignored.
REQ-022 DONE lasts one cycle: done=1, count=0; next state IDLE.
REQ-023 stop in RUN has priority over a wrap in the same cycle: no toggle, count<=0, next state IDLE, done stays 0.
REQ-024 stop in IDLE or DONE SHALL be ignored.
REQ-025 cmd_valid outside IDLE SHALL be ignored; the command is not consumed.
REQ-026 Latency: first count increment on the 1st RUN cycle after accept; a full sequence takes reps*(M+1) RUN cycles plus 1 DONE cycle.

Reset
REQ-027 reset=0 SHALL set: FSM=IDLE, count=0, wraps=0, out=0, done=0, busy=0, cmd_ready=1 after release; latched M and reps=0.
REQ-028 Reset asserted mid-RUN SHALL abort without a done pulse; the first command after release starts cleanly.

Configuration
REQ-029 Macro MODULO_SEQ_PAUSE_EN: when defined, input port pause (1 bit) SHALL exist; while pause=1 in RUN, count, wraps and out hold, and stop still takes effect.
REQ-030 Without MODULO_SEQ_PAUSE_EN, the pause port SHALL NOT exist and RUN advances every cycle.

Structure
REQ-031 Package modulo_seq_pkg SHALL hold the FSM state typedef and the default CNT_W/REP_W constants.
REQ-032 Sub-module modulo_tick SHALL contain the count register, the compare to M (wrap) and the toggle flop, with enable/clear inputs driven by the FSM.

Verification
REQ-033 Reset release, then M=2, reps=2 -> state 0,1,2,0,1,2; out toggles at each wrap (2 toggles); done pulses 1 cycle after the 6th RUN cycle; cmd_ready returns 1.
REQ-034 M=0, reps=3 -> out toggles on 3 consecutive cycles, then done.
REQ-035 M=7 (CNT_W=3), reps=0, stop after 20 RUN cycles -> wraps at 7 with no overflow; IDLE without done; count=0.
REQ-036 stop on the wrap cycle (count==M) -> no toggle, IDLE, done=0.
REQ-037 reset=0 asserted mid-RUN with out=1 -> out=0, count=0, IDLE immediately (asynchronous).
REQ-038 With MODULO_SEQ_PAUSE_EN: M=3, pause high for 4 cycles at count=2 -> count holds at 2, then resumes; total RUN cycles increase by 4.
